// File: rtl/adsr_envelope.sv
// adsr_envelope
// ADSR amplitude envelope between the waveform source and the PWM DAC.
// A gate-driven FSM advances a 16-bit envelope once per prescaled tick, and
// every sample is scaled about midscale (32768) by that envelope, so a
// released gate settles to silence at midscale with no DC step.
//
// Ports
//   clk            system clock (CLK100MHZ at top level)
//   rst            asynchronous, active-high reset
//   gate           note on/off, already synchronous to clk
//   attack_rate    attack step - 1 per tick
//   decay_rate     decay step - 1 per tick
//   sustain_level  sustain target, replicated to {sustain_level, sustain_level}
//   release_rate   release step - 1 per tick
//   sample_in      offset-binary sample, midscale 32768
//   level_out      scaled offset-binary sample, 2 clk after sample_in
//   env_out        current envelope value
//   state_out      IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
//   busy           state_out != IDLE
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | silent, env holds (0 after a completed release)
// ATTACK  | env rises by attack step per tick until it saturates at 65535
// DECAY   | env falls by decay step per tick down to the sustain target
// SUSTAIN | env tracks the sustain target on every tick
// RELEASE | env falls by release step per tick down to 0, then IDLE

module adsr_envelope #(
   parameter int TICK_DIV = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        gate,
   input  logic [7:0]  attack_rate,
   input  logic [7:0]  decay_rate,
   input  logic [7:0]  sustain_level,
   input  logic [7:0]  release_rate,
   input  logic [15:0] sample_in,
   output logic [15:0] level_out,
   output logic [15:0] env_out,
   output logic [2:0]  state_out,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ATTACK  = 3'd1,
      S_DECAY   = 3'd2,
      S_SUSTAIN = 3'd3,
      S_RELEASE = 3'd4
   } state_t;

   localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TICK_DIV - 1);

   state_t            state;
   state_t            state_nxt;
   logic [15:0]       env;
   logic [15:0]       env_nxt;
   logic              gate_q;
   logic              rise;
   logic              fall;
   logic              tick;
   logic [CNT_W-1:0]  tick_cnt;

   logic [15:0]       sus_tgt;
   logic [16:0]       step_a;
   logic [16:0]       step_d;
   logic [16:0]       step_r;
   logic [16:0]       sum_a;
   logic signed [16:0] diff_d;
   logic signed [16:0] diff_r;

   logic signed [15:0] smp_s;
   logic signed [16:0] env_s;
   logic signed [32:0] prod;
   logic signed [32:0] prod_q;
   logic [15:0]        level_q;
   logic               unused_prod_bits;

   // Tick timer: down-counter reloaded on terminal count, so the first tick
   // lands TICK_DIV cycles after reset and every TICK_DIV cycles thereafter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt <= CNT_LOAD;
      end else if (tick) begin
         tick_cnt <= CNT_LOAD;
      end else begin
         tick_cnt <= tick_cnt - 1'b1;
      end
   end

   assign tick = (tick_cnt == '0);
   assign rise = gate & ~gate_q;
   assign fall = ~gate & gate_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         env    <= 16'd0;
         gate_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         env    <= env_nxt;
         gate_q <= gate;
      end
   end

   // Decay/release differences are signed 17-bit so a step larger than env
   // goes negative instead of wrapping past the target.
   always_comb begin
      sus_tgt   = {sustain_level, sustain_level};
      step_a    = {9'd0, attack_rate} + 17'd1;
      step_d    = {9'd0, decay_rate} + 17'd1;
      step_r    = {9'd0, release_rate} + 17'd1;
      sum_a     = {1'b0, env} + step_a;
      diff_d    = signed'({1'b0, env} - step_d);
      diff_r    = signed'({1'b0, env} - step_r);
      state_nxt = state;
      env_nxt   = env;

      // Any gate edge owns the cycle; a coincident tick's env update is lost.
      if (rise) begin
         state_nxt = S_ATTACK;
      end else if (fall) begin
         if (state == S_ATTACK || state == S_DECAY || state == S_SUSTAIN) begin
            state_nxt = S_RELEASE;
         end
      end else if (tick) begin
         case (state)
            S_ATTACK: begin
               if (sum_a >= 17'd65535) begin
                  env_nxt   = 16'hFFFF;
                  state_nxt = S_DECAY;
               end else begin
                  env_nxt = sum_a[15:0];
               end
            end
            S_DECAY: begin
               if (diff_d <= signed'({1'b0, sus_tgt})) begin
                  env_nxt   = sus_tgt;
                  state_nxt = S_SUSTAIN;
               end else begin
                  env_nxt = diff_d[15:0];
               end
            end
            S_SUSTAIN: begin
               env_nxt = sus_tgt;
            end
            S_RELEASE: begin
               if (diff_r <= 17'sd0) begin
                  env_nxt   = 16'd0;
                  state_nxt = S_IDLE;
               end else begin
                  env_nxt = diff_r[15:0];
               end
            end
            default: begin
               env_nxt = env;
            end
         endcase
      end
   end

   // Scaling: centre the sample, multiply by the unsigned envelope, floor
   // shift by 16 and re-bias. |product| < 2^31, so the top bit and the low
   // 16 bits never reach the output.
   assign smp_s = signed'(sample_in ^ 16'h8000);
   assign env_s = signed'({1'b0, env});
   assign prod  = smp_s * env_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod_q  <= '0;
         level_q <= 16'h8000;
      end else begin
         prod_q  <= prod;
         level_q <= prod_q[31:16] ^ 16'h8000;
      end
   end

   assign unused_prod_bits = ^{prod_q[32], prod_q[15:0]};

   assign level_out = level_q;
   assign env_out   = env;
   assign state_out = state;
   assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// tb_adsr_envelope
// Scoreboarded bench for adsr_envelope. A driver applies directed and random
// stimulus at the falling edge, advances a plain-arithmetic envelope model
// and queues the expected post-edge outputs; a monitor pops and compares
// them after every rising edge.

module tb_adsr_envelope;

   localparam int TD = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        gate = 1'b0;
   logic [7:0]  attack_rate = 8'd255;
   logic [7:0]  decay_rate = 8'd15;
   logic [7:0]  sustain_level = 8'h80;
   logic [7:0]  release_rate = 8'd127;
   logic [15:0] sample_in = 16'h8000;
   logic [15:0] level_out;
   logic [15:0] env_out;
   logic [2:0]  state_out;
   logic        busy;

   always #5 clk = ~clk;

   adsr_envelope #(.TICK_DIV(TD)) dut (
      .clk           (clk),
      .rst           (rst),
      .gate          (gate),
      .attack_rate   (attack_rate),
      .decay_rate    (decay_rate),
      .sustain_level (sustain_level),
      .release_rate  (release_rate),
      .sample_in     (sample_in),
      .level_out     (level_out),
      .env_out       (env_out),
      .state_out     (state_out),
      .busy          (busy)
   );

   typedef struct {
      int env;
      int st;
      int lvl;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // reference model: envelope, phase (0..4), last gate, cycles into tick
   // period, pending product and output level
   int     m_env, m_st, m_gq, m_cnt, m_lvl;
   longint m_p;

   function automatic void chk(string nm, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      m_env = 0; m_st = 0; m_gq = 0; m_cnt = 0; m_p = 0; m_lvl = 32768;
   endfunction

   function automatic int floor_div16(longint v);
      longint q;
      q = v / 65536;
      if (v < 0 && q * 65536 != v) q = q - 1;
      return int'(q);
   endfunction

   // Predict the upcoming rising edge from current inputs, queue the
   // expectation, then advance to the next falling edge.
   task automatic step();
      int   rise, fall, tick, tgt, nenv, nst, e;
      exp_t x;
      if (rst) begin
         model_reset();
      end else begin
         rise = (gate == 1'b1 && m_gq == 0);
         fall = (gate == 1'b0 && m_gq == 1);
         tick = (m_cnt == TD - 1);
         tgt  = int'(sustain_level) * 257;
         nenv = m_env;
         nst  = m_st;
         if (rise) nst = 1;
         else if (fall) begin
            if (m_st >= 1 && m_st <= 3) nst = 4;
         end else if (tick) begin
            if (m_st == 1) begin
               e = m_env + int'(attack_rate) + 1;
               if (e >= 65535) begin nenv = 65535; nst = 2; end
               else nenv = e;
            end else if (m_st == 2) begin
               e = m_env - int'(decay_rate) - 1;
               if (e <= tgt) begin nenv = tgt; nst = 3; end
               else nenv = e;
            end else if (m_st == 3) begin
               nenv = tgt;
            end else if (m_st == 4) begin
               e = m_env - int'(release_rate) - 1;
               if (e <= 0) begin nenv = 0; nst = 0; end
               else nenv = e;
            end
         end
         m_lvl = floor_div16(m_p) + 32768;
         m_p   = longint'(int'(sample_in) - 32768) * longint'(m_env);
         m_env = nenv;
         m_st  = nst;
         m_gq  = int'(gate);
         m_cnt = (m_cnt + 1) % TD;
      end
      x.env = m_env;
      x.st  = m_st;
      x.lvl = m_lvl;
      sb.push_back(x);
      @(negedge clk);
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            chk("sb_env",   int'(env_out),   x.env);
            chk("sb_state", int'(state_out), x.st);
            chk("sb_busy",  int'(busy),      int'(x.st != 0));
            chk("sb_level", int'(level_out), x.lvl);
         end
      end
   end

   initial begin : driver
      int prev, changes, e0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_level", int'(level_out), 32768);
      chk("rst_env",   int'(env_out),   0);
      chk("rst_state", int'(state_out), 0);

      // climb to ~10000, then reset asynchronously with gate still high
      rst  = 1'b0;
      gate = 1'b1;
      for (int i = 0; i < 200 * TD && env_out < 16'd10000; i++) step();
      chk("pre_rst_env_reached", int'(env_out >= 16'd10000), 1);
      rst = 1'b1;
      #1;
      chk("async_rst_level", int'(level_out), 32768);
      chk("async_rst_env",   int'(env_out),   0);
      chk("async_rst_state", int'(state_out), 0);
      chk("async_rst_busy",  int'(busy),      0);
      model_reset();
      step();
      step();
      rst = 1'b0;
      step();
      chk("rise_after_rst", int'(state_out), 1);

      // attack: 256 steps of 256 up to 65535
      prev = env_out; changes = 0;
      for (int i = 0; i < 300 * TD && state_out == 3'd1; i++) begin
         step();
         if (env_out != prev) changes++;
         prev = env_out;
      end
      chk("attack_ticks", changes, 256);
      chk("attack_peak",  int'(env_out),   65535);
      chk("attack_done",  int'(state_out), 2);

      // decay by 16 per tick to 0x8080
      prev = env_out; changes = 0;
      for (int i = 0; i < 2100 * TD && state_out == 3'd2; i++) begin
         step();
         if (env_out != prev) changes++;
         prev = env_out;
      end
      chk("decay_ticks",  changes, 2040);
      chk("decay_target", int'(env_out),   32896);
      chk("decay_done",   int'(state_out), 3);

      sustain_level = 8'hFF;
      prev = env_out;
      for (int i = 0; i < 2 * TD + 2 && env_out == prev; i++) step();
      chk("sustain_follow", int'(env_out), 65535);

      sample_in = 16'hFFFF; step(); step();
      chk("scale_full_max", int'(level_out), 65534);
      sample_in = 16'h0000; step(); step();
      chk("scale_full_min", int'(level_out), 0);
      sample_in = 16'h8000; step(); step();
      chk("scale_full_mid", int'(level_out), 32768);

      sustain_level = 8'h80;
      prev = env_out;
      for (int i = 0; i < 2 * TD + 2 && env_out == prev; i++) step();
      chk("sustain_back", int'(env_out), 32896);
      sample_in = 16'hFFFF; step(); step();
      chk("scale_half_max", int'(level_out), 49215);

      // release: 32896 / 128 = 257 ticks
      release_rate = 8'd127;
      gate = 1'b0;
      step();
      chk("release_enter", int'(state_out), 4);
      prev = env_out; changes = 0;
      for (int i = 0; i < 300 * TD && state_out == 3'd4; i++) begin
         step();
         if (env_out != prev) changes++;
         prev = env_out;
      end
      chk("release_ticks", changes, 257);
      chk("release_env",   int'(env_out), 0);
      chk("release_busy",  int'(busy),    0);

      sample_in = 16'(($urandom % 65535) + 1);
      step(); step();
      chk("idle_silent", int'(level_out), 32768);

      // retrigger out of release around 20000
      gate = 1'b1;
      for (int i = 0; i < 200 * TD && env_out < 16'd30000; i++) step();
      release_rate = 8'd99;
      gate = 1'b0;
      step();
      for (int i = 0; i < 200 * TD && env_out > 16'd20000; i++) step();
      chk("retrig_in_release", int'(state_out), 4);
      e0 = env_out;
      gate = 1'b1;
      step();
      chk("retrig_state", int'(state_out), 1);
      chk("retrig_keep",  int'(env_out),   e0);
      for (int i = 0; i < 2 * TD + 2 && env_out == 16'(e0); i++) step();
      chk("retrig_climb", int'(env_out), e0 + 256);

      // gate edges landing exactly on tick cycles
      for (int i = 0; i < TD && m_cnt != TD - 1; i++) step();
      e0 = env_out;
      gate = 1'b0;
      step();
      chk("coinc_fall_state", int'(state_out), 4);
      chk("coinc_fall_env",   int'(env_out),   e0);
      for (int i = 0; i < TD && m_cnt != TD - 1; i++) step();
      e0 = env_out;
      gate = 1'b1;
      step();
      chk("coinc_rise_state", int'(state_out), 1);
      chk("coinc_rise_env",   int'(env_out),   e0);

      // random phase
      for (int i = 0; i < 30000; i++) begin
         sample_in = 16'($urandom);
         if ($urandom_range(63) == 0) begin
            attack_rate   = 8'($urandom_range(255, 32));
            decay_rate    = 8'($urandom_range(255, 32));
            release_rate  = 8'($urandom_range(255, 32));
            sustain_level = 8'($urandom);
         end
         if ($urandom_range(1499) == 0) gate = ~gate;
         if ($urandom_range(4999) == 0) rst = 1'b1;
         else rst = 1'b0;
         step();
      end
      rst  = 1'b0;
      gate = 1'b0;
      repeat (3) step();
      @(posedge clk);
      #2;
      chk("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
